// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle for the round-robin arbiter: N requester lanes in,
// one merged stream out.
interface stream_rr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [SW-1:0]      out_src;
    logic               busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src, busy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter with a main/skid output buffer,
// so in_ready never depends combinationally on out_ready.
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    localparam int SW   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_rr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_d;
    logic [SW-1:0]  grant, grant_d;
    logic [SW-1:0]  rr_ptr, rr_ptr_d;
    logic [SW-1:0]  pick;
    logic           found;

    logic [N-1:0]     ready;
    logic [WIDTH-1:0] lanes [N];
    logic             accept;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_last;
    logic [SW-1:0]    main_src;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_last;
    logic [SW-1:0]    skid_src;
    logic             drain;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lanes[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        logic [SW:0] sum;
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            if (!found && bus.in_valid[sum[SW-1:0]]) begin
                found = 1'b1;
                pick  = sum[SW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == LOCKED && !skid_valid) begin
            ready[grant] = 1'b1;
        end
    end

    assign accept    = |(ready & bus.in_valid);
    assign beat_data = lanes[grant];
    assign beat_last = bus.in_last[grant];
    assign drain     = main_valid && bus.out_ready;

    always_comb begin
        state_d  = state;
        grant_d  = grant;
        rr_ptr_d = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && beat_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant == SW'(N-1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            grant  <= grant_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Accept while full-and-stalled goes to skid; skid refills main on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            main_src   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_src   <= '0;
        end else if (accept && main_valid && !bus.out_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= beat_data;
            skid_last  <= beat_last;
            skid_src   <= grant;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= beat_data;
            main_last  <= beat_last;
            main_src   <= grant;
        end else if (drain) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_last  <= skid_last;
                main_src   <= skid_src;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_last  = main_last;
    assign bus.out_src   = main_src;
    assign bus.busy      = (state == LOCKED);
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: per-requester beat queues feed the
// inputs, a scoreboard queue of expected beats is checked by a monitor.
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           delay;
    } beat_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    stream_rr_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    stream_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t  bq [N][$];
    exp_t   exp_q [$];
    logic   orq [$];
    int     ts [$];
    int     cnt [N];
    logic [N-1:0] fire = '0;
    int     vec = 0;
    int     bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vec++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic beat(input int r, input logic [W-1:0] d,
                        input logic l, input int dly);
        beat_t b;
        b.data = d; b.last = l; b.delay = dly;
        bq[r].push_back(b);
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic l,
                               input int s);
        exp_t e;
        e.data = d; e.last = l; e.src = 2'(s);
        exp_q.push_back(e);
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic settle(input string nm);
        int n = 0;
        @(negedge clk); #4;
        while (!(exp_q.size() == 0 && all_empty() && !bus.busy
                 && !bus.out_valid) && n < 300) begin
            @(negedge clk); #4;
            n++;
        end
        vec++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s: timeout, %0d beats pending", nm, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Driver: presents queue heads, honours per-beat valid gaps.
    initial begin
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic [N-1:0]   l;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.in_last = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (fire[i] && bq[i].size() > 0) begin
                    void'(bq[i].pop_front());
                    if (bq[i].size() > 0) cnt[i] = bq[i][0].delay;
                end
            end
            v = '0; d = '0; l = '0;
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() == 0) begin
                    cnt[i] = 0;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                end else begin
                    v[i] = 1'b1;
                    d[i*W +: W] = bq[i][0].data;
                    l[i] = bq[i][0].last;
                end
            end
            bus.in_valid = v;
            bus.in_data = d;
            bus.in_last = l;
            bus.out_ready = (orq.size() > 0) ? orq.pop_front() : 1'b1;
            #4;
            fire = bus.in_valid & bus.in_ready;
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        int mcyc = 0;
        exp_t e;
        forever begin
            @(negedge clk); #4;
            mcyc++;
            if (bus.out_valid && bus.out_ready) begin
                ts.push_back(mcyc);
                vec++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_beat: unexpected data %h src %0d",
                             bus.out_data, bus.out_src);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last
                        || bus.out_src !== e.src) begin
                        bad++;
                        $display("FAIL out_beat: got %h/%b/%0d want %h/%b/%0d",
                                 bus.out_data, bus.out_last, bus.out_src,
                                 e.data, e.last, e.src);
                    end
                end
            end
        end
    end

    initial begin
        #1;
        // Reset held with everyone requesting 2-beat packets, 2 per source.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < 2; b++) begin
                    beat(i, 32'(i*256 + p*16 + b), b == 1, 0);
                    expect_beat(32'(i*256 + p*16 + b), b == 1, i);
                end
            end
        end
        @(negedge clk); #4;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_out_bits", {bus.out_data[27:0], bus.out_last, bus.out_src,
            1'b0}, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #4;
        chk("first_grant_busy", 32'(bus.busy), 32'h1);
        chk("first_grant_ready", 32'(bus.in_ready), 32'h1);
        settle("rr_2beat");
        chk("rr_throughput", 32'(ts[1] - ts[0]), 32'd1);
        chk("rr_bubble", 32'(ts[2] - ts[1]), 32'd2);
        chk("rr_span", 32'(ts[15] - ts[0]), 32'd22);
        ts.delete();

        // Move rr_ptr to 1, then a lone request from 3, then 0 vs 3.
        beat(0, 32'h3000, 1'b1, 0); expect_beat(32'h3000, 1'b1, 0);
        settle("ptr_to_1");
        beat(3, 32'h3300, 1'b0, 0); expect_beat(32'h3300, 1'b0, 3);
        beat(3, 32'h3301, 1'b1, 0); expect_beat(32'h3301, 1'b1, 3);
        settle("lone_3");
        beat(0, 32'h3400, 1'b1, 0); beat(3, 32'h3403, 1'b1, 0);
        expect_beat(32'h3400, 1'b1, 0);
        expect_beat(32'h3403, 1'b1, 3);
        settle("wrap_0_over_3");

        // Skid: 4 beats with out_ready stalls.
        for (int b = 0; b < 4; b++) begin
            beat(2, 32'(8'hA0 + b), b == 3, 0);
            expect_beat(32'(8'hA0 + b), b == 3, 2);
        end
        orq.push_back(1'b1); orq.push_back(1'b0); orq.push_back(1'b0);
        orq.push_back(1'b1); orq.push_back(1'b1); orq.push_back(1'b0);
        orq.push_back(1'b1);
        repeat (3) @(negedge clk);
        #4 chk("skid_pre_ready", 32'(bus.in_ready), 32'h4);
        @(negedge clk);
        #4 chk("skid_full_ready", 32'(bus.in_ready), 32'h0);
        settle("skid");

        // Granted requester 1 pauses 3 cycles; requester 2 must wait.
        beat(1, 32'h5101, 1'b0, 0);
        beat(1, 32'h5102, 1'b0, 3);
        beat(1, 32'h5103, 1'b1, 0);
        beat(2, 32'h5201, 1'b1, 0);
        expect_beat(32'h5101, 1'b0, 1);
        expect_beat(32'h5102, 1'b0, 1);
        expect_beat(32'h5103, 1'b1, 1);
        expect_beat(32'h5201, 1'b1, 2);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("pause_ready", 32'(bus.in_ready), 32'h2);
            chk("pause_busy", 32'(bus.busy), 32'h1);
            @(negedge clk);
        end
        settle("pause");

        // Async reset with skid full, then arbitration restarts at 0.
        for (int b = 0; b < 4; b++) beat(0, 32'(32'h6000 + b), b == 3, 0);
        repeat (30) orq.push_back(1'b0);
        repeat (4) @(negedge clk);
        #1 chk("full_ready", 32'(bus.in_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < N; i++) bq[i].delete();
        orq.delete();
        exp_q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(1, 32'h7100, 1'b1, 0); beat(3, 32'h7300, 1'b1, 0);
        expect_beat(32'h7100, 1'b1, 1);
        expect_beat(32'h7300, 1'b1, 3);
        settle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
